// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Brief    : Expands one padded 512-bit block into SHA-256 schedule words
//            W[0..ROUNDS-1] and streams them one per cycle over valid/ready,
//            using a 16-word sliding window.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] block_in,
    input  logic         block_valid,
    output logic         block_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_index,
    output logic         w_valid,
    input  logic         w_ready,
    output logic         w_last,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_IDX = 6'(ROUNDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_win [16];
    logic [5:0]  r_t;

    logic        w_accept;
    logic        w_xfer;
    logic        w_at_last;
    logic [31:0] w_new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next window word W[t+16]; wraps modulo 2^32.
    assign w_new_word = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];
    assign w_at_last  = (r_t == c_LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        block_ready  = 1'b0;
        w_valid      = 1'b0;
        w_out        = 32'd0;
        w_index      = 6'd0;
        w_last       = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE: begin
                block_ready = 1'b1;
                if (block_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                w_valid = 1'b1;
                w_out   = r_win[0];
                w_index = r_t;
                w_last  = w_at_last;
                if (w_ready) begin
                    w_xfer = 1'b1;
                    if (w_at_last) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Leaving only on a low block_valid keeps a sticky producer
                // from having its block processed twice.
                if (!block_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_t     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_t <= 6'd0;
                for (int i = 0; i < 16; i++) begin
                    r_win[i] <= block_in[511 - 32*i -: 32];
                end
            end else if (w_xfer && !w_at_last) begin
                r_t <= r_t + 6'd1;
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_new_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Brief    : Self-checking bench for sha256_msg_schedule against an array-based
//            SHA-256 schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] block_in = '0;
    logic         block_valid = 1'b0;
    logic         block_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_index;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic         w_last;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_w   [64];
    logic [31:0] cap     [64];
    logic [31:0] cap_ref [64];

    typedef struct {
        string        name;
        logic [511:0] blk;
        int           idx;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ONES = {512{1'b1}};

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .block_in    (block_in),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .w_out       (w_out),
        .w_index     (w_index),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_last      (w_last),
        .done        (done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Full 64-entry schedule, textbook recurrence.
    task automatic build_ref(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = blk[511 - 32*t -: 32];
            else        ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic [511:0] blk, input int idx,
                           input logic [31:0] exp);
        vec_t v;
        v.name = name; v.blk = blk; v.idx = idx; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic rearm();
        block_valid = 1'b0;
        step();
        chk("rearm_block_ready", block_ready, 1);
        chk("rearm_done", done, 0);
    endtask

    // Expects IDLE on entry; ends in DONE with block_valid still high.
    task automatic run_block(input logic [511:0] blk, input bit rand_ready, input int stall_at);
        int          idx, cyc, stall_cnt;
        bit          rdy, prev_stall;
        logic [31:0] prev_out;
        logic [5:0]  prev_idx;
        build_ref(blk);
        chk("accept_block_ready", block_ready, 1);
        block_in    = blk;
        block_valid = 1'b1;
        w_ready     = 1'b0;
        step();
        block_in   = rand_block();
        idx        = 0;
        cyc        = 0;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_idx   = '0;
        while (!done && cyc < 400) begin
            if (!w_valid) begin
                chk("w_valid_mid_block", w_valid, 1);
                break;
            end
            if (idx > 63) begin
                chk("extra_word", idx, 63);
                break;
            end
            if (prev_stall) begin
                chk("stall_hold_w_out", w_out, prev_out);
                chk("stall_hold_w_index", w_index, prev_idx);
            end
            chk("w_index", w_index, idx);
            chk("block_ready_stream", block_ready, 0);
            if (idx == stall_at && stall_cnt < 5) begin
                rdy = 1'b0;
                stall_cnt++;
            end else if (rand_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            w_ready = rdy;
            if (rdy) begin
                cap[idx] = w_out;
                chk("w_out", w_out, ref_w[idx]);
                chk("w_last", w_last, idx == 63);
                idx++;
            end
            prev_stall = !rdy;
            prev_out   = w_out;
            prev_idx   = w_index;
            step();
            cyc++;
        end
        w_ready = 1'b0;
        chk("done_reached", done, 1);
        chk("words_emitted", idx, 64);
        chk("w_valid_in_done", w_valid, 0);
        chk("block_ready_in_done", block_ready, 0);
        if (!rand_ready && stall_at < 0) chk("cycles_to_done", cyc, 64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism, cyc;
        logic [511:0] prev_blk;

        // Reset with a block already presented: nothing may be accepted.
        rst = 1'b1; block_valid = 1'b1; block_in = ABC; w_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_block_ready", block_ready, 1);
            chk("rst_w_valid", w_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_w_out", w_out, 0);
        end
        rst = 1'b0; block_valid = 1'b0; w_ready = 1'b0;
        step();
        chk("post_rst_w_valid", w_valid, 0);

        add_vec("abc_w0",  ABC,  0,  32'h61626380);
        add_vec("abc_w1",  ABC,  1,  32'h00000000);
        add_vec("abc_w14", ABC,  14, 32'h00000000);
        add_vec("abc_w15", ABC,  15, 32'h00000018);
        add_vec("abc_w16", ABC,  16, 32'h61626380);
        add_vec("abc_w17", ABC,  17, 32'h000F0000);
        add_vec("abc_w63", ABC,  63, 32'h12B1EDEB);
        add_vec("ones_w0", ONES, 0,  32'hFFFFFFFF);
        add_vec("ones_w15", ONES, 15, 32'hFFFFFFFF);
        add_vec("ones_w16", ONES, 16, 32'h203FFFFC);

        prev_blk = '0;
        foreach (vecs[i]) begin
            if (i == 0 || vecs[i].blk != prev_blk) begin
                if (i != 0) rearm();
                run_block(vecs[i].blk, 1'b0, -1);
                prev_blk = vecs[i].blk;
            end
            chk(vecs[i].name, cap[vecs[i].idx], vecs[i].exp);
        end

        // Backpressure: random ready plus a 5-cycle stall at t=20.
        rearm();
        run_block(ABC, 1'b0, -1);
        cap_ref = cap;
        rearm();
        run_block(ABC, 1'b1, 20);
        mism = 0;
        for (int t = 0; t < 64; t++) if (cap[t] !== cap_ref[t]) mism++;
        chk("backpressure_identical", mism, 0);

        // Sticky block_valid held through DONE.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sticky_done", done, 1);
            chk("sticky_no_w_valid", w_valid, 0);
            chk("sticky_block_ready", block_ready, 0);
        end
        rearm();
        run_block(ABC, 1'b0, -1);

        // Reset mid-stream at t=30.
        rearm();
        block_in = rand_block(); block_valid = 1'b1; w_ready = 1'b1;
        step();
        cyc = 0;
        while (!(w_valid && w_index == 6'd30) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("reached_t30", w_index, 30);
        rst = 1'b1;
        step();
        chk("midrst_w_valid", w_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_block_ready", block_ready, 1);
        rst = 1'b0; block_valid = 1'b0; w_ready = 1'b0;
        step();
        run_block(rand_block(), 1'b0, -1);

        for (int k = 0; k < 3; k++) begin
            rearm();
            run_block(rand_block(), 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
